fp_int_mul_serial: RTL and testbench

- Parametrised bit-serial FP16 x INT-N multiplier for the FP-INT MAC array; successor to the fixed 4-bit unsigned multiplier.
- Takes one FP activation and a weight streamed MSB-first over a runtime-selected 1..MAX_PREC cycles, with unsigned or two's-complement weights.
- Emits sign, exponent and an exact un-normalised product magnitude for the downstream accumulator.
- Forwards act/w/valid one cycle later so PEs chain systolically.

---
 rtl/fp_int_mul_serial_if.sv | 38 +++
 rtl/fp_int_mul_serial.sv | 164 ++++++++++++++++
 tb/tb_fp_int_mul_serial.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fp_int_mul_serial_if.sv
// Operand/result bundle for the bit-serial FP x INT multiplier.
// The master drives activation and weight bits; the slave returns the product and forwards inputs.
interface fp_int_mul_serial_if #(
    parameter int EXP_WIDTH  = 5,
    parameter int MAN_WIDTH  = 10,
    parameter int MAX_PREC   = 8,
    parameter int PREC_WIDTH = 4,
    parameter int ACT_WIDTH  = 1 + EXP_WIDTH + MAN_WIDTH,
    parameter int PROD_WIDTH = MAN_WIDTH + 1 + MAX_PREC
);
    logic [ACT_WIDTH-1:0]  act;
    logic                  w;
    logic                  in_valid;
    logic [PREC_WIDTH-1:0] precision;
    logic                  w_signed;

    logic                  out_valid;
    logic                  sign_out;
    logic [EXP_WIDTH-1:0]  exp_out;
    logic [PROD_WIDTH-1:0] mant_out;
    logic                  zero_out;
    logic                  busy;
    logic [ACT_WIDTH-1:0]  act_fwd;
    logic                  w_fwd;
    logic                  valid_fwd;

    modport master (
        output act, w, in_valid, precision, w_signed,
        input  out_valid, sign_out, exp_out, mant_out, zero_out, busy,
        input  act_fwd, w_fwd, valid_fwd
    );

    modport slave (
        input  act, w, in_valid, precision, w_signed,
        output out_valid, sign_out, exp_out, mant_out, zero_out, busy,
        output act_fwd, w_fwd, valid_fwd
    );
endinterface

// File: rtl/fp_int_mul_serial.sv
// Bit-serial FP16 x INT-N multiplier: MSB-first weight bits build an exact, un-normalised
// product of the hidden-1 mantissa and the weight, with systolic forwarding of the inputs.
//
// state  | meaning
// S_IDLE | waiting for a first weight bit (a P == 1 operation completes here)
// S_ACC  | accumulating weight bits 2..P, holding while in_valid is low
module fp_int_mul_serial #(
    parameter int EXP_WIDTH  = 5,
    parameter int MAN_WIDTH  = 10,
    parameter int MAX_PREC   = 8,
    parameter int PREC_WIDTH = 4,
    parameter int ACT_WIDTH  = 1 + EXP_WIDTH + MAN_WIDTH,
    parameter int PROD_WIDTH = MAN_WIDTH + 1 + MAX_PREC
) (
    input  logic              clk,
    input  logic              rst,
    fp_int_mul_serial_if.slave bus
);
    localparam int ACC_WIDTH = PROD_WIDTH + 1;

    typedef enum logic {S_IDLE, S_ACC} state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic signed [ACC_WIDTH-1:0]  w_acc_nxt;
    logic [PREC_WIDTH-1:0]        r_cnt;
    logic [PREC_WIDTH-1:0]        w_cnt_nxt;
    logic [PREC_WIDTH-1:0]        r_prec;
    logic [PREC_WIDTH-1:0]        w_prec_eff;
    logic [MAN_WIDTH:0]           r_m;
    logic [MAN_WIDTH:0]           w_m_in;
    logic signed [ACC_WIDTH-1:0]  w_m_ext_in;
    logic signed [ACC_WIDTH-1:0]  w_m_ext_r;
    logic [EXP_WIDTH-1:0]         r_exp;
    logic                         r_sign;
    logic [EXP_WIDTH-1:0]         w_fin_exp;
    logic                         w_fin_sign;
    logic                         w_first;
    logic                         w_done;
    logic                         w_acc_neg;
    logic                         w_is_zero;
    logic [PROD_WIDTH-1:0]        w_mag;

    logic                         r_out_valid;
    logic                         r_sign_out;
    logic [EXP_WIDTH-1:0]         r_exp_out;
    logic [PROD_WIDTH-1:0]        r_mant_out;
    logic                         r_zero_out;
    logic [ACT_WIDTH-1:0]         r_act_fwd;
    logic                         r_w_fwd;
    logic                         r_valid_fwd;

    // Out-of-range precision codes (0 or above MAX_PREC) run at full width.
    assign w_prec_eff = (bus.precision >= PREC_WIDTH'(1) && bus.precision <= PREC_WIDTH'(MAX_PREC))
                        ? bus.precision : PREC_WIDTH'(MAX_PREC);
    assign w_m_in     = {1'b1, bus.act[MAN_WIDTH-1:0]};
    assign w_m_ext_in = {{MAX_PREC{1'b0}}, w_m_in};
    assign w_m_ext_r  = {{MAX_PREC{1'b0}}, r_m};
    assign w_first    = (r_state == S_IDLE) && bus.in_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_done      = 1'b0;
        w_fin_exp   = r_exp;
        w_fin_sign  = r_sign;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_fin_exp  = bus.act[ACT_WIDTH-2 -: EXP_WIDTH];
                    w_fin_sign = bus.act[ACT_WIDTH-1];
                    // The MSB of a two's-complement weight carries negative weight.
                    if (bus.w) begin
                        w_acc_nxt = bus.w_signed ? -w_m_ext_in : w_m_ext_in;
                    end else begin
                        w_acc_nxt = '0;
                    end
                    w_cnt_nxt = PREC_WIDTH'(1);
                    if (w_prec_eff == PREC_WIDTH'(1)) begin
                        w_done = 1'b1;
                    end else begin
                        w_state_nxt = S_ACC;
                    end
                end
            end
            S_ACC: begin
                if (bus.in_valid) begin
                    w_acc_nxt = (r_acc <<< 1) + (bus.w ? w_m_ext_r : '0);
                    w_cnt_nxt = r_cnt + PREC_WIDTH'(1);
                    if (w_cnt_nxt == r_prec) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Subnormal activations (exponent 0) are flushed to a zero product.
    assign w_acc_neg = w_acc_nxt[ACC_WIDTH-1];
    assign w_mag     = PROD_WIDTH'(w_acc_neg ? -w_acc_nxt : w_acc_nxt);
    assign w_is_zero = (w_acc_nxt == '0) || (w_fin_exp == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_prec      <= '0;
            r_m         <= '0;
            r_exp       <= '0;
            r_sign      <= 1'b0;
            r_out_valid <= 1'b0;
            r_sign_out  <= 1'b0;
            r_exp_out   <= '0;
            r_mant_out  <= '0;
            r_zero_out  <= 1'b0;
            r_act_fwd   <= '0;
            r_w_fwd     <= 1'b0;
            r_valid_fwd <= 1'b0;
        end else begin
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_valid <= w_done;
            if (w_first) begin
                r_prec <= w_prec_eff;
                r_m    <= w_m_in;
                r_exp  <= bus.act[ACT_WIDTH-2 -: EXP_WIDTH];
                r_sign <= bus.act[ACT_WIDTH-1];
            end
            if (w_done) begin
                r_exp_out  <= w_fin_exp;
                r_zero_out <= w_is_zero;
                r_mant_out <= w_is_zero ? '0 : w_mag;
                r_sign_out <= w_is_zero ? 1'b0 : (w_fin_sign ^ w_acc_neg);
            end
            r_act_fwd   <= bus.act;
            r_w_fwd     <= bus.w;
            r_valid_fwd <= bus.in_valid;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.sign_out  = r_sign_out;
    assign bus.exp_out   = r_exp_out;
    assign bus.mant_out  = r_mant_out;
    assign bus.zero_out  = r_zero_out;
    assign bus.busy      = (r_state == S_ACC);
    assign bus.act_fwd   = r_act_fwd;
    assign bus.w_fwd     = r_w_fwd;
    assign bus.valid_fwd = r_valid_fwd;
endmodule

// File: tb/tb_fp_int_mul_serial.sv
// Scoreboard bench for fp_int_mul_serial: directed operations push hand-computed results
// and the completion cycle; a monitor pops on every out_valid and also checks forwarding.
module tb_fp_int_mul_serial;
    localparam int EW = 5;
    localparam int MW = 10;
    localparam int MP = 8;
    localparam int PW = 4;
    localparam int AW = 1 + EW + MW;
    localparam int DW = MW + 1 + MP;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fp_int_mul_serial_if #(.EXP_WIDTH(EW), .MAN_WIDTH(MW), .MAX_PREC(MP), .PREC_WIDTH(PW)) bus ();

    fp_int_mul_serial #(.EXP_WIDTH(EW), .MAN_WIDTH(MW), .MAX_PREC(MP), .PREC_WIDTH(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [DW-1:0] mant;
        logic [EW-1:0] exp;
        logic          sign;
        logic          zero;
        int            cyc;
    } exp_t;

    exp_t sbq[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int busy_cnt = 0;

    logic [AW-1:0] p_act = '0;
    logic p_w = 1'b0;
    logic p_v = 1'b0;
    logic p_ok = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        p_act <= bus.act;
        p_w   <= bus.w;
        p_v   <= bus.in_valid;
        p_ok  <= rst;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic monitor_step();
        exp_t e;
        if (bus.busy === 1'b1) busy_cnt++;
        if (rst && p_ok)
            check("forwarding", {bus.act_fwd, bus.w_fwd, bus.valid_fwd}, {p_act, p_w, p_v});
        if (rst && bus.out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_out_valid: got mant %0d, required no pulse (t=%0t)",
                         bus.mant_out, $time);
            end else begin
                e = sbq.pop_front();
                check("result{mant,exp,sign,zero}",
                      {bus.mant_out, bus.exp_out, bus.sign_out, bus.zero_out},
                      {e.mant, e.exp, e.sign, e.zero});
                check("out_valid_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.in_valid  = 1'b0;
            bus.w         = 1'b0;
            bus.act       = 16'h1234;
            bus.precision = 4'd3;
        end
    endtask

    // Only the first bit carries real act/precision/w_signed; later bits drive junk there.
    task automatic send_op(input logic [AW-1:0] a, input logic [PW-1:0] prec, input logic sgn,
                           input logic [7:0] wv, input int nb, input int stall_after,
                           input int stall_len, input logic [DW-1:0] em, input logic [EW-1:0] ee,
                           input logic es, input logic ez);
        exp_t e;
        for (int i = 0; i < nb; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.w        = wv[nb-1-i];
            if (i == 0) begin
                bus.act       = a;
                bus.precision = prec;
                bus.w_signed  = sgn;
            end else begin
                bus.act       = 16'h5555;
                bus.precision = 4'd2;
                bus.w_signed  = ~sgn;
            end
            if (i == nb - 1) begin
                e.mant = em; e.exp = ee; e.sign = es; e.zero = ez;
                e.cyc  = cyc + 1;
                sbq.push_back(e);
            end
            if (i + 1 == stall_after) begin
                for (int s = 0; s < stall_len; s++) begin
                    @(posedge clk); #1;
                    bus.in_valid = 1'b0;
                    bus.w        = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0;
        bus.act = '0; bus.w = 1'b0; bus.in_valid = 1'b0; bus.precision = '0; bus.w_signed = 1'b0;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {bus.out_valid, bus.sign_out, bus.exp_out, bus.mant_out, bus.zero_out,
                              bus.busy, bus.act_fwd, bus.w_fwd, bus.valid_fwd}, 64'd0);
        rst = 1'b1;
        idle(2);

        b0 = busy_cnt;
        send_op(16'h3C00, 4'd4, 1'b0, 8'b0101, 4, 0, 0, 19'd5120, 5'd15, 1'b0, 1'b0);
        idle(3);
        check("busy_seen_4bit", 64'(busy_cnt > b0), 64'd1);

        send_op(16'h3C00, 4'd4, 1'b1, 8'b1101, 4, 0, 0, 19'd3072, 5'd15, 1'b1, 1'b0);
        idle(2);
        send_op(16'hBC00, 4'd4, 1'b1, 8'b1101, 4, 0, 0, 19'd3072, 5'd15, 1'b0, 1'b0);
        idle(2);
        send_op(16'h3FFF, 4'd8, 1'b1, 8'h80, 8, 0, 0, 19'd262016, 5'd15, 1'b1, 1'b0);
        idle(2);
        send_op(16'h3FFF, 4'd8, 1'b0, 8'hFF, 8, 0, 0, 19'd521985, 5'd15, 1'b0, 1'b0);
        idle(2);
        send_op(16'h4A00, 4'd2, 1'b0, 8'b11, 2, 0, 0, 19'd4608, 5'd18, 1'b0, 1'b0);
        idle(2);

        send_op(16'h3C00, 4'd4, 1'b0, 8'b0101, 4, 2, 3, 19'd5120, 5'd15, 1'b0, 1'b0);
        idle(2);

        send_op(16'h3C00, 4'd4, 1'b0, 8'b0101, 4, 0, 0, 19'd5120, 5'd15, 1'b0, 1'b0);
        send_op(16'hBC00, 4'd4, 1'b1, 8'b1101, 4, 0, 0, 19'd3072, 5'd15, 1'b0, 1'b0);
        idle(3);

        b0 = busy_cnt;
        send_op(16'h3C00, 4'd1, 1'b1, 8'b1, 1, 0, 0, 19'd1024, 5'd15, 1'b1, 1'b0);
        idle(3);
        check("busy_never_p1", 64'(busy_cnt - b0), 64'd0);

        send_op(16'h0000, 4'd4, 1'b0, 8'b0101, 4, 0, 0, 19'd0, 5'd0, 1'b0, 1'b1);
        idle(2);
        send_op(16'hBC00, 4'd4, 1'b0, 8'b0000, 4, 0, 0, 19'd0, 5'd15, 1'b0, 1'b1);
        idle(2);
        send_op(16'h3C00, 4'd0, 1'b0, 8'h03, 8, 0, 0, 19'd3072, 5'd15, 1'b0, 1'b0);
        idle(2);
        send_op(16'h3C00, 4'd12, 1'b0, 8'h02, 8, 0, 0, 19'd2048, 5'd15, 1'b0, 1'b0);
        idle(3);

        // Two bits of a 4-bit op, then reset mid-operation.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            bus.in_valid  = 1'b1;
            bus.w         = 1'b1;
            bus.act       = 16'h3C00;
            bus.precision = 4'd4;
            bus.w_signed  = 1'b0;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("reset_midop", {bus.out_valid, bus.sign_out, bus.exp_out, bus.mant_out, bus.zero_out,
                              bus.busy, bus.act_fwd, bus.w_fwd, bus.valid_fwd}, 64'd0);
        idle(2);
        rst = 1'b1;
        idle(2);
        send_op(16'h3C00, 4'd4, 1'b0, 8'b0101, 4, 0, 0, 19'd5120, 5'd15, 1'b0, 1'b0);
        idle(3);

        for (int k = 0; k < 50 && sbq.size() != 0; k++) @(posedge clk);
        if (sbq.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d results outstanding, required 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
